sts_stream_pkt_gen: RTL and testbench

- Parametrised AXI4-Stream status-packet generator for the DMA S2MM status/APP channel.
- On each trigger pulse it emits one NUM_WORDS-beat packet: header flag word, sequence number, zero padding, then the captured byte count on the tlast beat.
- Full valid/ready backpressure compliance: data is held stable while stalled. Triggers that arrive while a packet is in flight are dropped and counted.

---
 rtl/sts_stream_pkt_gen.sv | 152 +++++++++++++++
 tb/tb_sts_stream_pkt_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sts_stream_pkt_gen.sv
// ---------------------------------------------------------------------------
// sts_stream_pkt_gen
//
// Emits one fixed-length AXI4-Stream status packet per accepted trigger,
// for the DMA S2MM status/APP channel. Packet layout by beat index:
//   0              : HEADER_WORD (zero-extended)
//   1              : packet sequence number (zero-extended)
//   2..NUM_WORDS-2 : zero
//   NUM_WORDS-1    : byte_count captured at the trigger, with tlast
// With NUM_WORDS=2 the last-beat rule wins, so beat 1 carries byte_count.
// Triggers seen while a packet is in flight are dropped and counted.
//
// Ports:
//   m_axis_sts_aclk     in   clock, rising edge
//   m_axis_sts_aresetn  in   async active-low reset
//   trigger             in   one-cycle request for a packet
//   byte_count          in   value captured on an accepted trigger
//   busy                out  packet in flight (through the final handshake)
//   drop_count          out  ignored triggers, saturating at 255
//   m_axis_sts_tvalid   out  AXIS valid
//   m_axis_sts_tdata    out  AXIS data
//   m_axis_sts_tkeep    out  AXIS keep, all ones
//   m_axis_sts_tlast    out  AXIS last, final beat only
//   m_axis_sts_tready   in   AXIS ready
//
// State table:
//   state    | meaning
//   ST_IDLE  | no packet in flight, tvalid low, waiting for trigger
//   ST_SEND  | presenting beat idx, advancing on each handshake
// ---------------------------------------------------------------------------
module sts_stream_pkt_gen #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_WORDS   = 5,
  parameter logic [31:0] HEADER_WORD = 32'h5000_0000,
  parameter int unsigned SEQ_WIDTH   = 16
) (
  input  logic                    m_axis_sts_aclk,
  input  logic                    m_axis_sts_aresetn,
  input  logic                    trigger,
  input  logic [DATA_WIDTH-1:0]   byte_count,
  output logic                    busy,
  output logic [7:0]              drop_count,
  output logic                    m_axis_sts_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_sts_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_sts_tkeep,
  output logic                    m_axis_sts_tlast,
  input  logic                    m_axis_sts_tready
);

  localparam int unsigned           IDX_W    = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [DATA_WIDTH-1:0] HDR      = DATA_WIDTH'(HEADER_WORD);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt, idx_inc;
  logic [SEQ_WIDTH-1:0]    seq, seq_nxt;
  logic [DATA_WIDTH-1:0]   cap, cap_nxt;
  logic [7:0]              drop_nxt;
  logic                    tvalid_nxt, tlast_nxt;
  logic [DATA_WIDTH-1:0]   tdata_nxt;

  // Contents of beat i; the last-beat check precedes the seq check so that
  // a two-beat packet carries byte_count on beat 1.
  function automatic logic [DATA_WIDTH-1:0] beat_word(
    input logic [IDX_W-1:0]      i,
    input logic [SEQ_WIDTH-1:0]  s,
    input logic [DATA_WIDTH-1:0] c
  );
    if (i == '0)                return HDR;
    else if (i == LAST_IDX)     return c;
    else if (i == IDX_W'(1))    return DATA_WIDTH'(s);
    else                        return '0;
  endfunction

  assign m_axis_sts_tkeep = '1;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    seq_nxt    = seq;
    cap_nxt    = cap;
    tvalid_nxt = m_axis_sts_tvalid;
    tdata_nxt  = m_axis_sts_tdata;
    tlast_nxt  = m_axis_sts_tlast;
    idx_inc    = idx + IDX_W'(1);
    drop_nxt   = drop_count;

    // busy covers the final-handshake cycle, so a retrigger there is dropped
    if (trigger && busy && (drop_count != 8'hFF))
      drop_nxt = drop_count + 8'd1;

    case (state)
      ST_IDLE: begin
        if (trigger) begin
          state_nxt  = ST_SEND;
          cap_nxt    = byte_count;
          idx_nxt    = '0;
          tvalid_nxt = 1'b1;
          tdata_nxt  = HDR;
          tlast_nxt  = 1'b0;
        end
      end
      ST_SEND: begin
        if (m_axis_sts_tvalid && m_axis_sts_tready) begin
          if (idx == LAST_IDX) begin
            state_nxt  = ST_IDLE;
            idx_nxt    = '0;
            seq_nxt    = seq + SEQ_WIDTH'(1);
            tvalid_nxt = 1'b0;
            tdata_nxt  = '0;
            tlast_nxt  = 1'b0;
          end else begin
            idx_nxt    = idx_inc;
            tdata_nxt  = beat_word(idx_inc, seq, cap);
            tlast_nxt  = (idx_inc == LAST_IDX);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge m_axis_sts_aclk or negedge m_axis_sts_aresetn) begin
    if (!m_axis_sts_aresetn) begin
      state             <= ST_IDLE;
      idx               <= '0;
      seq               <= '0;
      cap               <= '0;
      drop_count        <= '0;
      busy              <= 1'b0;
      m_axis_sts_tvalid <= 1'b0;
      m_axis_sts_tdata  <= '0;
      m_axis_sts_tlast  <= 1'b0;
    end else begin
      state             <= state_nxt;
      idx               <= idx_nxt;
      seq               <= seq_nxt;
      cap               <= cap_nxt;
      drop_count        <= drop_nxt;
      busy              <= (state_nxt == ST_SEND);
      m_axis_sts_tvalid <= tvalid_nxt;
      m_axis_sts_tdata  <= tdata_nxt;
      m_axis_sts_tlast  <= tlast_nxt;
    end
  end

endmodule

// File: tb/tb_sts_stream_pkt_gen.sv
module tb_sts_stream_pkt_gen;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  logic [15:0] exp_seq;

  // default instance: DATA_WIDTH=32, NUM_WORDS=5, SEQ_WIDTH=16
  logic        d_trig, d_rdy, d_busy, d_tv, d_tl;
  logic [31:0] d_bc, d_td;
  logic [7:0]  d_drop;
  logic [3:0]  d_tk;

  // short-sequence instance: NUM_WORDS=3, SEQ_WIDTH=2 (exercises seq wrap)
  logic        s_trig, s_rdy, s_busy, s_tv, s_tl;
  logic [31:0] s_bc, s_td;
  logic [7:0]  s_drop;
  logic [3:0]  s_tk;

  // wide instance: DATA_WIDTH=64, NUM_WORDS=2
  logic        w_trig, w_rdy, w_busy, w_tv, w_tl;
  logic [63:0] w_bc, w_td;
  logic [7:0]  w_drop;
  logic [7:0]  w_tk;

  sts_stream_pkt_gen u_dut (
    .m_axis_sts_aclk(clk), .m_axis_sts_aresetn(rst_n),
    .trigger(d_trig), .byte_count(d_bc), .busy(d_busy), .drop_count(d_drop),
    .m_axis_sts_tvalid(d_tv), .m_axis_sts_tdata(d_td), .m_axis_sts_tkeep(d_tk),
    .m_axis_sts_tlast(d_tl), .m_axis_sts_tready(d_rdy)
  );

  sts_stream_pkt_gen #(.DATA_WIDTH(32), .NUM_WORDS(3), .SEQ_WIDTH(2)) u_seq (
    .m_axis_sts_aclk(clk), .m_axis_sts_aresetn(rst_n),
    .trigger(s_trig), .byte_count(s_bc), .busy(s_busy), .drop_count(s_drop),
    .m_axis_sts_tvalid(s_tv), .m_axis_sts_tdata(s_td), .m_axis_sts_tkeep(s_tk),
    .m_axis_sts_tlast(s_tl), .m_axis_sts_tready(s_rdy)
  );

  sts_stream_pkt_gen #(.DATA_WIDTH(64), .NUM_WORDS(2)) u_w (
    .m_axis_sts_aclk(clk), .m_axis_sts_aresetn(rst_n),
    .trigger(w_trig), .byte_count(w_bc), .busy(w_busy), .drop_count(w_drop),
    .m_axis_sts_tvalid(w_tv), .m_axis_sts_tdata(w_td), .m_axis_sts_tkeep(w_tk),
    .m_axis_sts_tlast(w_tl), .m_axis_sts_tready(w_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected beat of a default 5-word packet.
  function automatic logic [31:0] exp_beat(int i, logic [15:0] s, logic [31:0] c);
    if (i == 0)      return 32'h5000_0000;
    else if (i == 4) return c;
    else if (i == 1) return {16'h0, s};
    else             return 32'h0;
  endfunction

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_assert++; if (d_tv !== 1'b0) begin n_fail++; $display("FAIL reset.tvalid: got %b expected 0", d_tv); end
    n_assert++; if (d_tl !== 1'b0) begin n_fail++; $display("FAIL reset.tlast: got %b expected 0", d_tl); end
    n_assert++; if (d_td !== 32'h0) begin n_fail++; $display("FAIL reset.tdata: got %h expected 0", d_td); end
    n_assert++; if (d_busy !== 1'b0) begin n_fail++; $display("FAIL reset.busy: got %b expected 0", d_busy); end
    n_assert++; if (d_drop !== 8'h0) begin n_fail++; $display("FAIL reset.drop: got %h expected 0", d_drop); end
    n_assert++; if (d_tk !== 4'hF) begin n_fail++; $display("FAIL reset.tkeep: got %h expected f", d_tk); end
    rst_n = 1'b1;
    @(negedge clk);
    n_assert++; if (d_tv !== 1'b0) begin n_fail++; $display("FAIL reset.idle_tvalid: got %b expected 0", d_tv); end
  endtask

  task automatic test_basic;
    d_rdy = 1'b1; d_bc = 32'h1234; d_trig = 1'b1;
    @(negedge clk);
    d_trig = 1'b0; d_bc = 32'hFFFF_FFFF;  // must not reach the in-flight packet
    for (int i = 0; i < 5; i++) begin
      n_assert++; if (d_tv !== 1'b1) begin n_fail++; $display("FAIL basic.tvalid[%0d]: got %b expected 1", i, d_tv); end
      n_assert++; if (d_td !== exp_beat(i, exp_seq, 32'h1234)) begin n_fail++; $display("FAIL basic.tdata[%0d]: got %h expected %h", i, d_td, exp_beat(i, exp_seq, 32'h1234)); end
      n_assert++; if (d_tl !== (i == 4)) begin n_fail++; $display("FAIL basic.tlast[%0d]: got %b expected %b", i, d_tl, (i == 4)); end
      n_assert++; if (d_busy !== 1'b1) begin n_fail++; $display("FAIL basic.busy[%0d]: got %b expected 1", i, d_busy); end
      @(negedge clk);
    end
    n_assert++; if (d_tv !== 1'b0) begin n_fail++; $display("FAIL basic.end_tvalid: got %b expected 0", d_tv); end
    n_assert++; if (d_tl !== 1'b0) begin n_fail++; $display("FAIL basic.end_tlast: got %b expected 0", d_tl); end
    n_assert++; if (d_td !== 32'h0) begin n_fail++; $display("FAIL basic.end_tdata: got %h expected 0", d_td); end
    n_assert++; if (d_busy !== 1'b0) begin n_fail++; $display("FAIL basic.end_busy: got %b expected 0", d_busy); end
    exp_seq++;
  endtask

  task automatic test_stall;
    d_rdy = 1'b1; d_bc = 32'h1234; d_trig = 1'b1;
    @(negedge clk);
    d_trig = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_assert++; if (d_td !== exp_beat(i, exp_seq, 32'h1234)) begin n_fail++; $display("FAIL stall.tdata[%0d]: got %h expected %h", i, d_td, exp_beat(i, exp_seq, 32'h1234)); end
      n_assert++; if (d_tl !== (i == 4)) begin n_fail++; $display("FAIL stall.tlast[%0d]: got %b expected %b", i, d_tl, (i == 4)); end
      if (i == 2) begin
        d_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          n_assert++; if (d_tv !== 1'b1) begin n_fail++; $display("FAIL stall.hold_tvalid[%0d]: got %b expected 1", k, d_tv); end
          n_assert++; if (d_td !== 32'h0) begin n_fail++; $display("FAIL stall.hold_tdata[%0d]: got %h expected 0", k, d_td); end
          n_assert++; if (d_tl !== 1'b0) begin n_fail++; $display("FAIL stall.hold_tlast[%0d]: got %b expected 0", k, d_tl); end
        end
        d_rdy = 1'b1;
      end
      @(negedge clk);
    end
    n_assert++; if (d_tv !== 1'b0) begin n_fail++; $display("FAIL stall.end_tvalid: got %b expected 0", d_tv); end
    exp_seq++;
  endtask

  task automatic test_back_to_back;
    d_rdy = 1'b1;
    for (int p = 0; p < 3; p++) begin
      d_bc = 32'hA000 + 32'(p); d_trig = 1'b1;
      @(negedge clk);
      d_trig = 1'b0;
      for (int i = 0; i < 5; i++) begin
        n_assert++; if (d_tv !== 1'b1) begin n_fail++; $display("FAIL b2b.tvalid[%0d.%0d]: got %b expected 1", p, i, d_tv); end
        n_assert++; if (d_td !== exp_beat(i, exp_seq, 32'hA000 + 32'(p))) begin n_fail++; $display("FAIL b2b.tdata[%0d.%0d]: got %h expected %h", p, i, d_td, exp_beat(i, exp_seq, 32'hA000 + 32'(p))); end
        @(negedge clk);
      end
      n_assert++; if (d_tv !== 1'b0) begin n_fail++; $display("FAIL b2b.gap_tvalid[%0d]: got %b expected 0", p, d_tv); end
      exp_seq++;
      @(negedge clk);
    end
  endtask

  task automatic test_final_drop;
    d_rdy = 1'b1; d_bc = 32'h55; d_trig = 1'b1;
    @(negedge clk);
    d_trig = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_assert++; if (d_td !== exp_beat(i, exp_seq, 32'h55)) begin n_fail++; $display("FAIL fdrop.tdata[%0d]: got %h expected %h", i, d_td, exp_beat(i, exp_seq, 32'h55)); end
      if (i == 4) d_trig = 1'b1;  // coincides with the final handshake
      @(negedge clk);
    end
    d_trig = 1'b0;
    n_assert++; if (d_tv !== 1'b0) begin n_fail++; $display("FAIL fdrop.tvalid: got %b expected 0", d_tv); end
    n_assert++; if (d_busy !== 1'b0) begin n_fail++; $display("FAIL fdrop.busy: got %b expected 0", d_busy); end
    n_assert++; if (d_drop !== 8'd1) begin n_fail++; $display("FAIL fdrop.drop_count: got %0d expected 1", d_drop); end
    @(negedge clk);
    n_assert++; if (d_tv !== 1'b0) begin n_fail++; $display("FAIL fdrop.tvalid_later: got %b expected 0", d_tv); end
    exp_seq++;
  endtask

  task automatic test_drop_saturation;
    d_rdy = 1'b1; d_bc = 32'h77; d_trig = 1'b1;
    @(negedge clk);
    d_trig = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_assert++; if (d_td !== exp_beat(i, exp_seq, 32'h77)) begin n_fail++; $display("FAIL sat.tdata[%0d]: got %h expected %h", i, d_td, exp_beat(i, exp_seq, 32'h77)); end
      n_assert++; if (d_tl !== (i == 4)) begin n_fail++; $display("FAIL sat.tlast[%0d]: got %b expected %b", i, d_tl, (i == 4)); end
      if (i == 2) begin
        d_rdy = 1'b0; d_trig = 1'b1;
        repeat (300) @(negedge clk);
        d_trig = 1'b0;
        n_assert++; if (d_drop !== 8'd255) begin n_fail++; $display("FAIL sat.drop_count: got %0d expected 255", d_drop); end
        n_assert++; if (d_tv !== 1'b1) begin n_fail++; $display("FAIL sat.tvalid: got %b expected 1", d_tv); end
        n_assert++; if (d_td !== 32'h0) begin n_fail++; $display("FAIL sat.hold_tdata: got %h expected 0", d_td); end
        n_assert++; if (d_busy !== 1'b1) begin n_fail++; $display("FAIL sat.busy: got %b expected 1", d_busy); end
        d_rdy = 1'b1;
      end
      @(negedge clk);
    end
    n_assert++; if (d_tv !== 1'b0) begin n_fail++; $display("FAIL sat.end_tvalid: got %b expected 0", d_tv); end
    n_assert++; if (d_drop !== 8'd255) begin n_fail++; $display("FAIL sat.end_drop: got %0d expected 255", d_drop); end
    exp_seq++;
  endtask

  task automatic test_reset_mid;
    d_rdy = 1'b1; d_bc = 32'h99; d_trig = 1'b1;
    @(negedge clk);
    d_trig = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++; if (d_tv !== 1'b1) begin n_fail++; $display("FAIL rstmid.pre_tvalid: got %b expected 1", d_tv); end
    #2 rst_n = 1'b0;
    #1;
    n_assert++; if (d_tv !== 1'b0) begin n_fail++; $display("FAIL rstmid.tvalid: got %b expected 0", d_tv); end
    n_assert++; if (d_td !== 32'h0) begin n_fail++; $display("FAIL rstmid.tdata: got %h expected 0", d_td); end
    n_assert++; if (d_tl !== 1'b0) begin n_fail++; $display("FAIL rstmid.tlast: got %b expected 0", d_tl); end
    n_assert++; if (d_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid.busy: got %b expected 0", d_busy); end
    n_assert++; if (d_drop !== 8'h0) begin n_fail++; $display("FAIL rstmid.drop: got %0d expected 0", d_drop); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_assert++; if (d_tv !== 1'b0) begin n_fail++; $display("FAIL rstmid.no_beat[%0d]: got %b expected 0", k, d_tv); end
    end
    exp_seq = 16'h0;
    d_bc = 32'h4321; d_trig = 1'b1;
    @(negedge clk);
    d_trig = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_assert++; if (d_td !== exp_beat(i, exp_seq, 32'h4321)) begin n_fail++; $display("FAIL rstmid.tdata[%0d]: got %h expected %h", i, d_td, exp_beat(i, exp_seq, 32'h4321)); end
      n_assert++; if (d_tl !== (i == 4)) begin n_fail++; $display("FAIL rstmid.tlast[%0d]: got %b expected %b", i, d_tl, (i == 4)); end
      @(negedge clk);
    end
    exp_seq++;
  endtask

  task automatic test_seq_wrap;
    logic [31:0] es;
    s_rdy = 1'b1;
    for (int p = 0; p < 5; p++) begin
      es = 32'(p % 4);
      s_bc = 32'h100 + 32'(p); s_trig = 1'b1;
      @(negedge clk);
      s_trig = 1'b0;
      n_assert++; if (s_td !== 32'h5000_0000) begin n_fail++; $display("FAIL wrap.hdr[%0d]: got %h expected 50000000", p, s_td); end
      @(negedge clk);
      n_assert++; if (s_td !== es) begin n_fail++; $display("FAIL wrap.seq[%0d]: got %h expected %h", p, s_td, es); end
      n_assert++; if (s_tl !== 1'b0) begin n_fail++; $display("FAIL wrap.tlast1[%0d]: got %b expected 0", p, s_tl); end
      @(negedge clk);
      n_assert++; if (s_td !== 32'h100 + 32'(p)) begin n_fail++; $display("FAIL wrap.count[%0d]: got %h expected %h", p, s_td, 32'h100 + 32'(p)); end
      n_assert++; if (s_tl !== 1'b1) begin n_fail++; $display("FAIL wrap.tlast2[%0d]: got %b expected 1", p, s_tl); end
      @(negedge clk);
      n_assert++; if (s_tv !== 1'b0) begin n_fail++; $display("FAIL wrap.end_tvalid[%0d]: got %b expected 0", p, s_tv); end
      @(negedge clk);
    end
    n_assert++; if (s_tk !== 4'hF) begin n_fail++; $display("FAIL wrap.tkeep: got %h expected f", s_tk); end
    n_assert++; if (s_drop !== 8'h0) begin n_fail++; $display("FAIL wrap.drop: got %0d expected 0", s_drop); end
    n_assert++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL wrap.busy: got %b expected 0", s_busy); end
  endtask

  task automatic test_w64;
    w_rdy = 1'b1; w_bc = 64'hCAFE_F00D_1234_5678; w_trig = 1'b1;
    @(negedge clk);
    w_trig = 1'b0; w_bc = 64'h0;
    n_assert++; if (w_tv !== 1'b1) begin n_fail++; $display("FAIL w64.tvalid0: got %b expected 1", w_tv); end
    n_assert++; if (w_td !== 64'h0000_0000_5000_0000) begin n_fail++; $display("FAIL w64.hdr: got %h expected 0000000050000000", w_td); end
    n_assert++; if (w_tl !== 1'b0) begin n_fail++; $display("FAIL w64.tlast0: got %b expected 0", w_tl); end
    n_assert++; if (w_tk !== 8'hFF) begin n_fail++; $display("FAIL w64.tkeep: got %h expected ff", w_tk); end
    n_assert++; if (w_busy !== 1'b1) begin n_fail++; $display("FAIL w64.busy: got %b expected 1", w_busy); end
    @(negedge clk);
    w_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_assert++; if (w_td !== 64'hCAFE_F00D_1234_5678) begin n_fail++; $display("FAIL w64.count[%0d]: got %h expected cafef00d12345678", k, w_td); end
      n_assert++; if (w_tl !== 1'b1) begin n_fail++; $display("FAIL w64.tlast1[%0d]: got %b expected 1", k, w_tl); end
      n_assert++; if (w_tv !== 1'b1) begin n_fail++; $display("FAIL w64.tvalid1[%0d]: got %b expected 1", k, w_tv); end
      @(negedge clk);
    end
    w_rdy = 1'b1;
    @(negedge clk);
    n_assert++; if (w_tv !== 1'b0) begin n_fail++; $display("FAIL w64.end_tvalid: got %b expected 0", w_tv); end
    n_assert++; if (w_td !== 64'h0) begin n_fail++; $display("FAIL w64.end_tdata: got %h expected 0", w_td); end
    n_assert++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL w64.end_busy: got %b expected 0", w_busy); end
    n_assert++; if (w_drop !== 8'h0) begin n_fail++; $display("FAIL w64.drop: got %0d expected 0", w_drop); end
  endtask

  initial begin
    n_assert = 0; n_fail = 0; exp_seq = 16'h0;
    rst_n = 1'b0;
    d_trig = 1'b0; d_bc = 32'h0; d_rdy = 1'b1;
    s_trig = 1'b0; s_bc = 32'h0; s_rdy = 1'b1;
    w_trig = 1'b0; w_bc = 64'h0; w_rdy = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_final_drop();
    test_drop_saturation();
    test_reset_mid();
    test_seq_wrap();
    test_w64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
